dmem_arbiter: RTL

- Shares the single-port, word-wide data memory between two requesters: M0 (core load/store path) and M1 (debug/DMA port).
- Sequences sub-word stores as read-modify-write, because the memory has no byte enables.
- Sits between the core's memory-result control stage and the data SRAM; replaces direct core-to-SRAM wiring.
- Memory is synchronous: read data is valid in the cycle after a read is issued.

---
 rtl/dmem_arbiter_pkg.sv | 27 ++
 rtl/dmem_byte_merge.sv | 20 ++
 rtl/dmem_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned LANE_W    = 8;
    localparam int unsigned WORD_W    = NUM_LANES * LANE_W;

    // Arbiter FSM state encodings
    typedef enum logic [1:0] {
        DMEM_ARB_IDLE = 2'd0,
        DMEM_ARB_RD   = 2'd1,
        DMEM_ARB_RESP = 2'd2,
        DMEM_ARB_WR   = 2'd3
    } dmem_arb_state_e;

    // Master ids
    localparam logic DMEM_M0 = 1'b0;
    localparam logic DMEM_M1 = 1'b1;

    localparam logic [NUM_LANES-1:0] BE_FULL = 4'b1111;

    // A partial store needs a read-modify-write; full and empty enables do not.
    function automatic logic is_partial_be(input logic [NUM_LANES-1:0] be);
        return (be != BE_FULL) && (be != '0);
    endfunction

endpackage

// File: rtl/dmem_byte_merge.sv
// Combinational 4-lane merge: lanes with be set take wdata, others keep rdata.
module dmem_byte_merge
    import dmem_arbiter_pkg::*;
(
    input  logic [NUM_LANES-1:0] be,
    input  logic [WORD_W-1:0]    wdata,
    input  logic [WORD_W-1:0]    rdata,
    output logic [WORD_W-1:0]    merged_c
);

    // Per-lane select between new store data and the word read back
    always_comb begin
        merged_c = '0;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            merged_c[i*LANE_W +: LANE_W] = be[i] ? wdata[i*LANE_W +: LANE_W]
                                                 : rdata[i*LANE_W +: LANE_W];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data SRAM; sub-word stores are
// sequenced as read-modify-write. Define DMEM_ARB_RR_EN for round-robin
// arbitration; otherwise M0 has fixed priority.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    input  logic [3:0]        m0_be_i,
    output logic              m0_gnt_o,
    output logic [DATA_W-1:0] m0_rdata_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    input  logic [3:0]        m1_be_i,
    output logic              m1_gnt_o,
    output logic [DATA_W-1:0] m1_rdata_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    dmem_arb_state_e   state;
    logic              win_id_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        be_q;

    logic              sel_m1;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic [3:0]        win_be;
    logic [DATA_W-1:0] merged_c;

`ifdef DMEM_ARB_RR_EN
    logic              rr_ptr;
    logic              rr_valid;
`endif

    dmem_byte_merge u_merge (
        .be       (be_q),
        .wdata    (wdata_q),
        .rdata    (mem_rdata_i),
        .merged_c (merged_c)
    );

    // Pick the winner among asserted requests
    always_comb begin
        sel_m1 = 1'b0;
`ifdef DMEM_ARB_RR_EN
        // rr_ptr holds the last winner; until the first grant M0 is preferred
        if (m0_req_i && m1_req_i) begin
            sel_m1 = rr_valid && (rr_ptr == DMEM_M0);
        end else begin
            sel_m1 = m1_req_i;
        end
`else
        sel_m1 = m1_req_i && !m0_req_i;
`endif
        win_we    = sel_m1 ? m1_we_i    : m0_we_i;
        win_addr  = sel_m1 ? m1_addr_i  : m0_addr_i;
        win_wdata = sel_m1 ? m1_wdata_i : m0_wdata_i;
        win_be    = sel_m1 ? m1_be_i    : m0_be_i;
    end

    // State register, request latches and arbitration pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= DMEM_ARB_IDLE;
            win_id_q <= DMEM_M0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
`ifdef DMEM_ARB_RR_EN
            rr_ptr   <= DMEM_M0;
            rr_valid <= 1'b0;
`endif
        end else begin
            unique case (state)
                DMEM_ARB_IDLE: begin
                    if (m0_req_i || m1_req_i) begin
                        win_id_q <= sel_m1 ? DMEM_M1 : DMEM_M0;
                        we_q     <= win_we;
                        addr_q   <= win_addr;
                        wdata_q  <= win_wdata;
                        be_q     <= win_be;
`ifdef DMEM_ARB_RR_EN
                        rr_ptr   <= sel_m1 ? DMEM_M1 : DMEM_M0;
                        rr_valid <= 1'b1;
`endif
                        if (!win_we || is_partial_be(win_be)) begin
                            state <= DMEM_ARB_RD;
                        end else begin
                            state <= DMEM_ARB_WR;
                        end
                    end
                end
                DMEM_ARB_RD: begin
                    state <= DMEM_ARB_RESP;
                end
                DMEM_ARB_RESP: begin
                    if (we_q) begin
                        // Merged word reuses the write-data latch for the WR cycle
                        wdata_q <= merged_c;
                        state   <= DMEM_ARB_WR;
                    end else begin
                        state   <= DMEM_ARB_IDLE;
                    end
                end
                DMEM_ARB_WR: begin
                    state <= DMEM_ARB_IDLE;
                end
                default: begin
                    state <= DMEM_ARB_IDLE;
                end
            endcase
        end
    end

    // Memory strobes, grants and read data decoded from state and latches
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        m0_gnt_o    = 1'b0;
        m1_gnt_o    = 1'b0;
        m0_rdata_o  = '0;
        m1_rdata_o  = '0;
        unique case (state)
            DMEM_ARB_RD: begin
                mem_en_o   = 1'b1;
                mem_addr_o = addr_q & WORD_MASK;
            end
            DMEM_ARB_RESP: begin
                if (!we_q) begin
                    if (win_id_q == DMEM_M1) begin
                        m1_gnt_o   = 1'b1;
                        m1_rdata_o = mem_rdata_i;
                    end else begin
                        m0_gnt_o   = 1'b1;
                        m0_rdata_o = mem_rdata_i;
                    end
                end
            end
            DMEM_ARB_WR: begin
                // be == 0 completes without touching memory
                mem_en_o    = |be_q;
                mem_we_o    = |be_q;
                mem_addr_o  = addr_q & WORD_MASK;
                mem_wdata_o = wdata_q;
                m0_gnt_o    = (win_id_q == DMEM_M0);
                m1_gnt_o    = (win_id_q == DMEM_M1);
            end
            default: begin
            end
        endcase
    end

endmodule
